// File: rtl/div16_pkg.sv
// Shared definitions for the 16-bit sequential divider: FSM states and sizing.
package div16_pkg;

    localparam int DIV16_W     = 16;
    localparam int DIV16_STEPS = 16;
    localparam int DIV16_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div16_state_t;

endpackage

// File: rtl/div16_step.sv
// One combinational restoring division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module div16_step
    import div16_pkg::*;
(
    input  logic [DIV16_W:0]   prem,
    input  logic               din_bit,
    input  logic [DIV16_W-1:0] divisor,
    output logic [DIV16_W:0]   rem_next,
    output logic               qbit
);

    logic [DIV16_W+1:0] shifted;
    logic [DIV16_W+1:0] trial;

    // Shift-subtract: the top bit of the widened difference is the borrow.
    always_comb begin
        shifted  = {prem, din_bit};
        trial    = shifted - {2'b00, divisor};
        qbit     = ~trial[DIV16_W+1];
        rem_next = qbit ? trial[DIV16_W:0] : shifted[DIV16_W:0];
    end

endmodule

// File: rtl/div16_seq.sv
// 16-bit sequential restoring divider, one quotient bit per clock.
// Define DIV16_SIGNED_EN to build two's-complement signed division
// (truncating toward zero); the default build is unsigned only.
module div16_seq
    import div16_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               div_start,
    input  logic [DIV16_W-1:0] div_dividend,
    input  logic [DIV16_W-1:0] div_divisor,
    output logic [DIV16_W-1:0] div_quot,
    output logic [DIV16_W-1:0] div_rem,
    output logic               div_busy,
    output logic               div_done,
    output logic               div_dbz
);

    div16_state_t           state;
    div16_state_t           state_next;
    logic [DIV16_CNT_W-1:0] count;
    logic [DIV16_W:0]       prem;
    logic [DIV16_W-1:0]     dq;
    logic [DIV16_W-1:0]     dvs;
    logic                   neg_q;
    logic                   neg_r;

    logic                   accept;
    logic                   divisor_zero;
    logic                   last_step;
    logic [DIV16_W:0]       rem_next;
    logic                   qbit;
    logic [DIV16_W-1:0]     quot_raw;

    logic [DIV16_W-1:0]     op_dividend;
    logic [DIV16_W-1:0]     op_divisor;
    logic                   op_neg_q;
    logic                   op_neg_r;

    function automatic logic [DIV16_W-1:0] magnitude(input logic signed [DIV16_W-1:0] v);
        return v[DIV16_W-1] ? DIV16_W'(-v) : v;
    endfunction

    function automatic logic [DIV16_W-1:0] apply_sign(input logic [DIV16_W-1:0] v,
                                                      input logic neg);
        return neg ? DIV16_W'(-v) : v;
    endfunction

    assign accept       = div_start && (state != ST_RUN);
    assign divisor_zero = (div_divisor == '0);
    assign last_step    = (state == ST_RUN) && (count == DIV16_CNT_W'(1));
    assign quot_raw     = {dq[DIV16_W-2:0], qbit};

    div16_step u_step (
        .prem     (prem),
        .din_bit  (dq[DIV16_W-1]),
        .divisor  (dvs),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // Operand conditioning at accept: magnitudes and result sign flags.
    always_comb begin
`ifdef DIV16_SIGNED_EN
        op_dividend = magnitude(div_dividend);
        op_divisor  = magnitude(div_divisor);
        op_neg_q    = div_dividend[DIV16_W-1] ^ div_divisor[DIV16_W-1];
        op_neg_r    = div_dividend[DIV16_W-1];
`else
        op_dividend = div_dividend;
        op_divisor  = div_divisor;
        op_neg_q    = 1'b0;
        op_neg_r    = 1'b0;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs; a zero divisor skips RUN entirely.
    always_comb begin
        state_next = state;
        div_busy   = 1'b0;
        div_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (div_start) begin
                    state_next = divisor_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                div_busy = 1'b1;
                if (count == DIV16_CNT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                div_done = 1'b1;
                if (div_start) begin
                    state_next = divisor_zero ? ST_DONE : ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in RUN, load results on DONE entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            prem     <= '0;
            dq       <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_quot <= '0;
            div_rem  <= '0;
            div_dbz  <= 1'b0;
        end else if (accept) begin
            prem  <= '0;
            dq    <= op_dividend;
            dvs   <= op_divisor;
            neg_q <= op_neg_q;
            neg_r <= op_neg_r;
            if (divisor_zero) begin
                count    <= '0;
                div_quot <= '1;
                div_rem  <= div_dividend;
                div_dbz  <= 1'b1;
            end else begin
                count    <= DIV16_CNT_W'(DIV16_STEPS);
                div_dbz  <= 1'b0;
            end
        end else if (state == ST_RUN) begin
            prem  <= rem_next;
            dq    <= quot_raw;
            count <= count - DIV16_CNT_W'(1);
            if (last_step) begin
                div_quot <= apply_sign(quot_raw, neg_q);
                div_rem  <= apply_sign(rem_next[DIV16_W-1:0], neg_r);
            end
        end
    end

endmodule

// File: tb/tb_div16_seq.sv
// Directed self-checking bench for div16_seq.
module tb_div16_seq;

    logic        clk;
    logic        rst;
    logic        div_start;
    logic [15:0] div_dividend;
    logic [15:0] div_divisor;
    logic [15:0] div_quot;
    logic [15:0] div_rem;
    logic        div_busy;
    logic        div_done;
    logic        div_dbz;

    int checks;
    int failures;
    int lat;
    int done_seen;

    div16_seq dut (
        .clk          (clk),
        .rst          (rst),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quot     (div_quot),
        .div_rem      (div_rem),
        .div_busy     (div_busy),
        .div_done     (div_done),
        .div_dbz      (div_dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one start and wait (bounded) for div_done; lat counts cycles after accept.
    task automatic do_div(input logic [15:0] a, input logic [15:0] b, output int l);
        div_start    = 1'b1;
        div_dividend = a;
        div_divisor  = b;
        tick();
        div_start    = 1'b0;
        l = 1;
        while (!div_done && l < 40) begin
            tick();
            l++;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        div_start = 1'b0;
        div_dividend = 16'd0;
        div_divisor = 16'd0;
        tick();
        tick();
        chk("rst_quot", div_quot, 16'd0);
        chk("rst_rem", div_rem, 16'd0);
        chk("rst_flags", {13'd0, div_busy, div_done, div_dbz}, 16'd0);
        rst = 1'b0;
        tick();

        // 100/7 with cycle-accurate busy/done profile
        div_start = 1'b1;
        div_dividend = 16'd100;
        div_divisor = 16'd7;
        tick();
        div_start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("run_busy_c%0d", i), {14'd0, div_busy, div_done}, 16'b10);
            tick();
        end
        chk("c17_done", {14'd0, div_busy, div_done}, 16'b01);
        chk("100_7_quot", div_quot, 16'd14);
        chk("100_7_rem", div_rem, 16'd2);
        chk("100_7_dbz", {15'd0, div_dbz}, 16'd0);
        tick();
        chk("after_done_idle", {14'd0, div_busy, div_done}, 16'b00);
        chk("hold_quot", div_quot, 16'd14);

        do_div(16'hFFFF, 16'd1, lat);
        chk("ffff_1_lat", 16'(lat), 16'd17);
        chk("ffff_1_quot", div_quot, 16'hFFFF);
        chk("ffff_1_rem", div_rem, 16'd0);
        tick();

        do_div(16'd5, 16'd9, lat);
        chk("5_9_quot", div_quot, 16'd0);
        chk("5_9_rem", div_rem, 16'd5);
        tick();

        // divide by zero
        do_div(16'd1234, 16'd0, lat);
        chk("dbz_lat", 16'(lat), 16'd1);
        chk("dbz_quot", div_quot, 16'hFFFF);
        chk("dbz_rem", div_rem, 16'd1234);
        chk("dbz_flag", {15'd0, div_dbz}, 16'd1);
        tick();
        chk("dbz_held", {15'd0, div_dbz}, 16'd1);

        // start during RUN is ignored; stale results held meanwhile
        div_start = 1'b1;
        div_dividend = 16'd200;
        div_divisor = 16'd3;
        tick();
        div_start = 1'b0;
        lat = 1;
        repeat (4) begin tick(); lat++; end
        div_start = 1'b1;
        div_dividend = 16'd9;
        div_divisor = 16'd4;
        tick();
        lat++;
        div_start = 1'b0;
        chk("run_stale_quot", div_quot, 16'hFFFF);
        chk("run_stale_rem", div_rem, 16'd1234);
        chk("run_dbz_clear", {15'd0, div_dbz}, 16'd0);
        while (!div_done && lat < 40) begin tick(); lat++; end
        chk("ignore_lat", 16'(lat), 16'd17);
        chk("ignore_quot", div_quot, 16'd66);
        chk("ignore_rem", div_rem, 16'd2);

        // back-to-back accept from DONE
        div_start = 1'b1;
        div_dividend = 16'd300;
        div_divisor = 16'd7;
        tick();
        div_start = 1'b0;
        chk("b2b_flags", {14'd0, div_busy, div_done}, 16'b10);
        lat = 1;
        while (!div_done && lat < 40) begin tick(); lat++; end
        chk("b2b_lat", 16'(lat), 16'd17);
        chk("b2b_quot", div_quot, 16'd42);
        chk("b2b_rem", div_rem, 16'd6);
        tick();

        // reset mid-RUN
        div_start = 1'b1;
        div_dividend = 16'd1000;
        div_divisor = 16'd3;
        tick();
        div_start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        #2;
        chk("midrst_quot", div_quot, 16'd0);
        chk("midrst_rem", div_rem, 16'd0);
        chk("midrst_flags", {13'd0, div_busy, div_done, div_dbz}, 16'd0);
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (div_done || div_busy) done_seen++;
            tick();
        end
        chk("no_done_after_rst", 16'(done_seen), 16'd0);
        do_div(16'd50, 16'd5, lat);
        chk("50_5_lat", 16'(lat), 16'd17);
        chk("50_5_quot", div_quot, 16'd10);
        chk("50_5_rem", div_rem, 16'd0);
        tick();

`ifdef DIV16_SIGNED_EN
        do_div(16'hFFF9, 16'd2, lat);
        chk("s_m7_2_lat", 16'(lat), 16'd17);
        chk("s_m7_2_quot", div_quot, 16'hFFFD);
        chk("s_m7_2_rem", div_rem, 16'hFFFF);
        tick();
        do_div(16'h8000, 16'hFFFF, lat);
        chk("s_min_m1_quot", div_quot, 16'h8000);
        chk("s_min_m1_rem", div_rem, 16'd0);
        tick();
`else
        do_div(16'hFFF9, 16'd2, lat);
        chk("u_fff9_2_quot", div_quot, 16'h7FFC);
        chk("u_fff9_2_rem", div_rem, 16'd1);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
